// File: rtl/tnoc_injector_pkg.sv
// Shared types for the packet injector: FSM state encoding, header fields and
// the header-word packing helper.
package tnoc_injector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_e;

    // Field containers are sized for the widest supported build; the packing
    // function uses the actual widths so narrower builds pack tightly.
    typedef struct packed {
        logic [7:0]  src_x;
        logic [7:0]  src_y;
        logic [7:0]  dest_x;
        logic [7:0]  dest_y;
        logic [15:0] length;
    } header_t;

    // Packs {src_x, src_y, dest_x, dest_y, length} into the LSBs, MSBs zero.
    function automatic logic [63:0] pack_header(input header_t h, input int xw,
                                                input int yw, input int lw);
        logic [63:0] w;
        w = 64'(h.src_x);
        w = (w << yw) | 64'(h.src_y);
        w = (w << xw) | 64'(h.dest_x);
        w = (w << yw) | 64'(h.dest_y);
        w = (w << lw) | 64'(h.length);
        return w;
    endfunction

endpackage

// File: rtl/tnoc_injector_out_reg.sv
// One-entry valid/ready flit register; the fabric's ready is selected by the
// VC of the flit currently held.
module tnoc_injector_out_reg #(
    parameter int CHANNELS   = 2,
    parameter int VC_W       = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_load_head,
    input  logic                  i_load_tail,
    input  logic [VC_W-1:0]       i_load_vc,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic [CHANNELS-1:0]   i_flit_ready,
    output logic                  o_free,
    output logic                  o_xfer,
    output logic                  o_flit_valid,
    output logic                  o_flit_head,
    output logic                  o_flit_tail,
    output logic [VC_W-1:0]       o_flit_vc,
    output logic [DATA_WIDTH-1:0] o_flit_data
);

    assign o_xfer = o_flit_valid && i_flit_ready[o_flit_vc];
    assign o_free = !o_flit_valid || o_xfer;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_flit_valid <= 1'b0;
            o_flit_head  <= 1'b0;
            o_flit_tail  <= 1'b0;
            o_flit_vc    <= '0;
            o_flit_data  <= '0;
        end else if (i_load) begin
            o_flit_valid <= 1'b1;
            o_flit_head  <= i_load_head;
            o_flit_tail  <= i_load_tail;
            o_flit_vc    <= i_load_vc;
            o_flit_data  <= i_load_data;
        end else if (o_xfer) begin
            o_flit_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tnoc_packet_injector.sv
// Local-port packet injector: request + payload stream -> head/payload/tail flits.
// Optional build macro TNOC_PACKET_INJECTOR_STATS_EN adds packet/flit counters.
module tnoc_packet_injector
    import tnoc_injector_pkg::*;
#(
    parameter int SIZE_X     = 4,
    parameter int SIZE_Y     = 4,
    parameter int ID_X_WIDTH = 2,
    parameter int ID_Y_WIDTH = 2,
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    localparam int VC_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_X_WIDTH-1:0] i_id_x,
    input  logic [ID_Y_WIDTH-1:0] i_id_y,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ID_X_WIDTH-1:0] i_req_dest_x,
    input  logic [ID_Y_WIDTH-1:0] i_req_dest_y,
    input  logic [VC_W-1:0]       i_req_vc,
    input  logic [LEN_WIDTH-1:0]  i_req_length,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_flit_valid,
    input  logic [CHANNELS-1:0]   i_flit_ready,
    output logic                  o_flit_head,
    output logic                  o_flit_tail,
    output logic [VC_W-1:0]       o_flit_vc,
    output logic [DATA_WIDTH-1:0] o_flit_data,
`ifdef TNOC_PACKET_INJECTOR_STATS_EN
    output logic [31:0]           o_packet_count,
    output logic [31:0]           o_flit_count,
`endif
    output logic                  o_busy,
    output logic                  o_error
);

    state_e                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [VC_W-1:0]        vc_q;
    logic                   run_q;
    logic                   free;
    logic                   xfer;
    logic                   req_fire;
    logic                   data_fire;
    logic                   dest_legal;
    logic                   load;
    logic                   load_tail;
    logic [VC_W-1:0]        load_vc;
    logic [DATA_WIDTH-1:0]  load_data;
    header_t                hdr;

    assign dest_legal = (32'(i_req_dest_x) < 32'(SIZE_X)) &&
                        (32'(i_req_dest_y) < 32'(SIZE_Y));

    // run_q keeps both readies low until the first edge after reset release.
    assign o_req_ready  = run_q && (state == IDLE) && free;
    assign o_data_ready = run_q && (((state == PAYLOAD) && free) || (state == DROP));
    assign req_fire     = i_req_valid && o_req_ready;
    assign data_fire    = i_data_valid && o_data_ready;
    assign o_busy       = (state != IDLE) || o_flit_valid;

    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        hdr        = '0;
        hdr.src_x  = 8'(i_id_x);
        hdr.src_y  = 8'(i_id_y);
        hdr.dest_x = 8'(i_req_dest_x);
        hdr.dest_y = 8'(i_req_dest_y);
        hdr.length = 16'(i_req_length);
        load       = 1'b0;
        load_tail  = 1'b0;
        load_vc    = vc_q;
        load_data  = i_data;
        if (state == IDLE) begin
            load      = req_fire && dest_legal;
            load_tail = (i_req_length == '0);
            load_vc   = i_req_vc;
            load_data = DATA_WIDTH'(pack_header(hdr, ID_X_WIDTH, ID_Y_WIDTH, LEN_WIDTH));
        end else if (state == PAYLOAD) begin
            load      = data_fire;
            load_tail = (remaining == LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            vc_q      <= '0;
            run_q     <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            o_error <= req_fire && !dest_legal;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        remaining <= i_req_length;
                        vc_q      <= i_req_vc;
                        if (i_req_length != '0)
                            state <= dest_legal ? PAYLOAD : DROP;
                    end
                end
                PAYLOAD, DROP: begin
                    if (data_fire) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tnoc_injector_out_reg #(
        .CHANNELS   (CHANNELS),
        .VC_W       (VC_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (load),
        .i_load_head  (state == IDLE),
        .i_load_tail  (load_tail),
        .i_load_vc    (load_vc),
        .i_load_data  (load_data),
        .i_flit_ready (i_flit_ready),
        .o_free       (free),
        .o_xfer       (xfer),
        .o_flit_valid (o_flit_valid),
        .o_flit_head  (o_flit_head),
        .o_flit_tail  (o_flit_tail),
        .o_flit_vc    (o_flit_vc),
        .o_flit_data  (o_flit_data)
    );

`ifdef TNOC_PACKET_INJECTOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_packet_count <= '0;
            o_flit_count   <= '0;
        end else begin
            if (xfer && (o_flit_count != '1))
                o_flit_count <= o_flit_count + 32'd1;
            if (xfer && o_flit_tail && (o_packet_count != '1))
                o_packet_count <= o_packet_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tnoc_packet_injector.sv
// Directed bench for tnoc_packet_injector; SIZE_X is 3 so dest_x=3 is illegal.
module tb_tnoc_packet_injector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  id_x = 2'd3;
    logic [1:0]  id_y = 2'd2;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_dest_x = '0;
    logic [1:0]  req_dest_y = '0;
    logic        req_vc = 1'b0;
    logic [7:0]  req_length = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data = '0;
    logic        flit_valid;
    logic [1:0]  flit_ready = 2'b11;
    logic        flit_head;
    logic        flit_tail;
    logic        flit_vc;
    logic [31:0] flit_data;
    logic        busy;
    logic        error;
`ifdef TNOC_PACKET_INJECTOR_STATS_EN
    logic [31:0] packet_count;
    logic [31:0] flit_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tnoc_packet_injector #(
        .SIZE_X(3), .SIZE_Y(4), .ID_X_WIDTH(2), .ID_Y_WIDTH(2),
        .CHANNELS(2), .DATA_WIDTH(32), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_id_x(id_x), .i_id_y(id_y),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_dest_x(req_dest_x), .i_req_dest_y(req_dest_y),
        .i_req_vc(req_vc), .i_req_length(req_length),
        .i_data_valid(data_valid), .o_data_ready(data_ready), .i_data(data),
        .o_flit_valid(flit_valid), .i_flit_ready(flit_ready),
        .o_flit_head(flit_head), .o_flit_tail(flit_tail),
        .o_flit_vc(flit_vc), .o_flit_data(flit_data),
`ifdef TNOC_PACKET_INJECTOR_STATS_EN
        .o_packet_count(packet_count), .o_flit_count(flit_count),
`endif
        .o_busy(busy), .o_error(error)
    );

    task automatic drive_req(input logic [1:0] dx, input logic [1:0] dy,
                             input logic vc, input logic [7:0] len);
        req_valid  = 1'b1;
        req_dest_x = dx;
        req_dest_y = dy;
        req_vc     = vc;
        req_length = len;
    endtask

    task automatic expect_flit(input string name, input logic head, input logic tail,
                               input logic vc, input logic [31:0] d);
        checks++;
        if (flit_valid !== 1'b1 || flit_head !== head || flit_tail !== tail ||
            flit_vc !== vc || flit_data !== d) begin
            errors++;
            $display("FAIL %s: got v=%b h=%b t=%b vc=%b d=%h, want v=1 h=%b t=%b vc=%b d=%h",
                     name, flit_valid, flit_head, flit_tail, flit_vc, flit_data,
                     head, tail, vc, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({flit_valid, flit_head, flit_tail, flit_vc, busy, error, req_ready, data_ready} !== 8'b0
            || flit_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b h=%b t=%b vc=%b busy=%b err=%b rr=%b dr=%b d=%h, want all 0",
                     flit_valid, flit_head, flit_tail, flit_vc, busy, error, req_ready, data_ready, flit_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got req_ready=%b busy=%b, want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_header_only();
        drive_req(2'd2, 2'd1, 1'b1, 8'd0);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("hdr_only_flit", 1'b1, 1'b1, 1'b1, 32'h0000_E900);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hdr_only_busy: got %b, want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (flit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hdr_only_drain: got valid=%b busy=%b, want 0 0", flit_valid, busy);
        end
    endtask

    task automatic test_payload();
        drive_req(2'd1, 2'd3, 1'b0, 8'd3);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("pay_head", 1'b1, 1'b0, 1'b0, 32'h0000_E703);
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL pay_data_ready: got %b, want 1", data_ready);
        end
        data_valid = 1'b1;
        data = 32'hA;
        @(negedge clk);
        expect_flit("pay_A", 1'b0, 1'b0, 1'b0, 32'hA);
        data = 32'hB;
        @(negedge clk);
        expect_flit("pay_B", 1'b0, 1'b0, 1'b0, 32'hB);
        data = 32'hC;
        @(negedge clk);
        expect_flit("pay_C", 1'b0, 1'b1, 1'b0, 32'hC);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL pay_req_ready_at_tail: got %b, want 1", req_ready);
        end
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL pay_drain: got valid=%b, want 0", flit_valid);
        end
    endtask

    task automatic test_backpressure();
        drive_req(2'd0, 2'd0, 1'b1, 8'd2);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("bp_head", 1'b1, 1'b0, 1'b1, 32'h0000_E002);
        data_valid = 1'b1;
        data = 32'h11;
        @(negedge clk);
        expect_flit("bp_first", 1'b0, 1'b0, 1'b1, 32'h11);
        data = 32'h22;
        flit_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_flit("bp_hold", 1'b0, 1'b0, 1'b1, 32'h11);
            checks++;
            if (data_ready !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_low cycle %0d: got data_ready=%b req_ready=%b, want 0 0",
                         i, data_ready, req_ready);
            end
        end
        flit_ready = 2'b11;
        @(negedge clk);
        expect_flit("bp_resume", 1'b0, 1'b1, 1'b1, 32'h22);
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (flit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b busy=%b, want 0 0", flit_valid, busy);
        end
    endtask

    task automatic test_illegal_dest();
        drive_req(2'd3, 2'd0, 1'b0, 8'd2);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || flit_valid !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_accept: got err=%b valid=%b data_ready=%b, want 1 0 1",
                     error, flit_valid, data_ready);
        end
        data_valid = 1'b1;
        data = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || flit_valid !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_word0: got err=%b valid=%b data_ready=%b, want 0 0 1",
                     error, flit_valid, data_ready);
        end
        data = 32'hBEEF;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if (error !== 1'b0 || flit_valid !== 1'b0 || data_ready !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_done: got err=%b valid=%b dr=%b busy=%b rr=%b, want 0 0 0 0 1",
                     error, flit_valid, data_ready, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if (flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_no_flit: got valid=%b, want 0", flit_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(2'd1, 2'd1, 1'b0, 8'd1);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("b2b_head1", 1'b1, 1'b0, 1'b0, 32'h0000_E501);
        data_valid = 1'b1;
        data = 32'h55;
        @(negedge clk);
        expect_flit("b2b_tail1", 1'b0, 1'b1, 1'b0, 32'h55);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_req_ready: got %b, want 1", req_ready);
        end
        data_valid = 1'b0;
        drive_req(2'd2, 2'd0, 1'b1, 8'd0);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("b2b_head2", 1'b1, 1'b1, 1'b1, 32'h0000_E800);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive_req(2'd0, 2'd1, 1'b1, 8'd4);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("rst_head", 1'b1, 1'b0, 1'b1, 32'h0000_E104);
        data_valid = 1'b1;
        data = 32'h101;
        @(negedge clk);
        data = 32'h102;
        @(negedge clk);
        data = 32'h103;
        @(negedge clk);
        expect_flit("rst_p3", 1'b0, 1'b0, 1'b1, 32'h103);
`ifdef TNOC_PACKET_INJECTOR_STATS_EN
        checks++;
        if (flit_count !== 32'd3 || packet_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_before_reset: got flits=%0d packets=%0d, want 3 0",
                     flit_count, packet_count);
        end
`endif
        data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flit_valid, flit_head, flit_tail, flit_vc, busy, req_ready, data_ready} !== 7'b0
            || flit_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b h=%b t=%b vc=%b busy=%b rr=%b dr=%b d=%h, want all 0",
                     flit_valid, flit_head, flit_tail, flit_vc, busy, req_ready, data_ready, flit_data);
        end
`ifdef TNOC_PACKET_INJECTOR_STATS_EN
        checks++;
        if (flit_count !== 32'd0 || packet_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_after_reset: got flits=%0d packets=%0d, want 0 0",
                     flit_count, packet_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (flit_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_tail: got valid=%b req_ready=%b, want 0 1", flit_valid, req_ready);
        end
        drive_req(2'd1, 2'd0, 1'b0, 8'd0);
        @(negedge clk);
        req_valid = 1'b0;
        expect_flit("rst_new_head", 1'b1, 1'b1, 1'b0, 32'h0000_E400);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_header_only();
        test_payload();
        test_backpressure();
        test_illegal_dest();
        test_back_to_back();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
